// File: rtl/rom_cipher_decoder.sv
// ROM cipher decoder: walks the cipher ROM image, reads the header words
// (operation, key, stop character), then decodes one cipher word per
// character and writes the zero-extended plaintext byte into data RAM.
// The run ends after the decoded stop character is written, or with an
// error on a bad operation code or when MAX_CHARS characters are used up.
module rom_cipher_decoder #(
   parameter logic [10:0] ROM_BASE  = 11'h000,
   parameter logic [10:0] RAM_BASE  = 11'h100,
   parameter int          MAX_CHARS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [10:0] rom_address,
   input  logic [31:0] rom_data,
   output logic        ram_we,
   output logic [10:0] ram_address,
   output logic [31:0] ram_wdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  char_count
);

   localparam logic [8:0]  LP_MAX       = 9'(MAX_CHARS);
   localparam logic [10:0] LP_KEY_ADDR  = ROM_BASE + 11'd4;
   localparam logic [10:0] LP_STOP_ADDR = ROM_BASE + 11'd8;
   localparam logic [10:0] LP_CHAR_BASE = ROM_BASE + 11'd12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_OP,
      S_RD_KEY,
      S_RD_STOP,
      S_RD_CHAR,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [1:0]  r_op;
   logic [7:0]  r_key;
   logic [7:0]  r_stop;
   logic [7:0]  r_index;
   logic [7:0]  r_byte;
   logic [7:0]  r_count;

   logic        w_opValid;
   logic [7:0]  w_decoded;
   logic [10:0] w_charOffset;
   logic        w_isStop;
   logic        w_isLast;

   // Whole header word must be 1, 2 or 3; anything else is a bad operation.
   assign w_opValid    = (rom_data == 32'd1) || (rom_data == 32'd2) || (rom_data == 32'd3);
   assign w_charOffset = {1'b0, r_index, 2'b00};
   assign w_isStop     = (r_byte == r_stop);
   assign w_isLast     = (({1'b0, r_index} + 9'd1) == LP_MAX);
   assign char_count   = r_count;

   // Decode the low byte of the current cipher word with the captured operation and key.
   always_comb begin
      w_decoded = 8'd0;
      case (r_op)
         2'd1:    w_decoded = rom_data[7:0] ^ r_key;
         2'd2:    w_decoded = ~rom_data[7:0];
         default: w_decoded = rom_data[7:0] - r_key;
      endcase
   end

   // State register; reset aborts any run immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: three header reads, then read/write pairs per character.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: if (start) w_next = S_RD_OP;
         S_RD_OP:               w_next = w_opValid ? S_RD_KEY : S_ERR;
         S_RD_KEY:              w_next = S_RD_STOP;
         S_RD_STOP:             w_next = S_RD_CHAR;
         S_RD_CHAR:             w_next = S_WRITE;
         S_WRITE: begin
            if (w_isStop) begin
               w_next = S_DONE;
            end else if (w_isLast) begin
               w_next = S_ERR;
            end else begin
               w_next = S_RD_CHAR;
            end
         end
         default:               w_next = S_IDLE;
      endcase
   end

   // Datapath registers: header capture, character index, decoded byte and write count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= 2'd0;
         r_key   <= 8'd0;
         r_stop  <= 8'd0;
         r_index <= 8'd0;
         r_byte  <= 8'd0;
         r_count <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) r_count <= 8'd0;
            S_RD_OP:               r_op <= rom_data[1:0];
            S_RD_KEY:              r_key <= rom_data[7:0];
            S_RD_STOP: begin
               r_stop  <= rom_data[7:0];
               r_index <= 8'd0;
            end
            S_RD_CHAR:             r_byte <= w_decoded;
            S_WRITE: begin
               r_count <= r_count + 8'd1;
               if (!w_isStop && !w_isLast) r_index <= r_index + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // Output decode: ROM address per read state, RAM strobe only in the write state.
   always_comb begin
      rom_address = ROM_BASE;
      ram_we      = 1'b0;
      ram_address = 11'd0;
      ram_wdata   = 32'd0;
      busy        = 1'b1;
      done        = 1'b0;
      error       = 1'b0;
      case (r_state)
         S_IDLE:    busy = 1'b0;
         S_RD_OP:   rom_address = ROM_BASE;
         S_RD_KEY:  rom_address = LP_KEY_ADDR;
         S_RD_STOP: rom_address = LP_STOP_ADDR;
         S_RD_CHAR: rom_address = LP_CHAR_BASE + w_charOffset;
         S_WRITE: begin
            ram_we      = 1'b1;
            ram_address = RAM_BASE + w_charOffset;
            ram_wdata   = {24'd0, r_byte};
         end
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         S_ERR: begin
            busy  = 1'b0;
            error = 1'b1;
         end
         default:   busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_rom_cipher_decoder.sv
// Testbench for rom_cipher_decoder. Two instances share one ROM image and
// one start/reset: the default MAX_CHARS=64 and a short MAX_CHARS=4 variant.
// A run-level reference model derives the plaintext list and the cycle
// timeline from the ROM contents; one compare process checks every cycle.
module tb_rom_cipher_decoder;

   localparam logic [10:0] ROM_BASE = 11'h000;
   localparam logic [10:0] RAM_BASE = 11'h100;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;

   logic [31:0] rom [512];
   logic [31:0] ram0 [512];

   logic [10:0] ra0, ra1, wa0, wa1;
   logic [31:0] rd0, rd1, wd0, wd1;
   logic        we0, we1, b0, b1, d0, d1, e0, e1;
   logic [7:0]  cc0, cc1;

   int checks = 0;
   int failures = 0;
   int runEdge = 0;
   bit runActive = 1'b0;
   int checkLimit = 0;
   int doneRise0 = -1;
   int busyFirst0 = -1;
   int busyLast0 = -1;
   int wc0 = 0;
   int wc1 = 0;

   int          expT [2];
   int          expN [2];
   bit          expDoneFlag [2];
   bit          expOpOk [2];
   logic [7:0]  expByte [2][256];

   assign rd0 = rom[ra0[10:2]];
   assign rd1 = rom[ra1[10:2]];

   always #5 clk = ~clk;

   rom_cipher_decoder #(.ROM_BASE(ROM_BASE), .RAM_BASE(RAM_BASE), .MAX_CHARS(64)) dut0 (
      .clk(clk), .rst(rst), .start(start),
      .rom_address(ra0), .rom_data(rd0),
      .ram_we(we0), .ram_address(wa0), .ram_wdata(wd0),
      .busy(b0), .done(d0), .error(e0), .char_count(cc0)
   );

   rom_cipher_decoder #(.ROM_BASE(ROM_BASE), .RAM_BASE(RAM_BASE), .MAX_CHARS(4)) dut1 (
      .clk(clk), .rst(rst), .start(start),
      .rom_address(ra1), .rom_data(rd1),
      .ram_we(we1), .ram_address(wa1), .ram_wdata(wd1),
      .busy(b1), .done(d1), .error(e1), .char_count(cc1)
   );

   task automatic cmp(input string name, input int inst, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s inst=%0d edge=%0d actual=0x%0h expected=0x%0h",
                  name, inst, k, act, exp);
      end
   endtask

   function automatic logic [7:0] plainOf(input int op, input logic [7:0] c, input logic [7:0] k);
      case (op)
         1:       return c ^ k;
         2:       return ~c;
         default: return c - k;
      endcase
   endfunction

   // Reference model: walk the ROM image and list the plaintext bytes a run writes.
   task automatic modelRun(input int inst);
      int maxc;
      int op;
      logic [7:0] key, stop, p;
      maxc = (inst == 0) ? 64 : 4;
      op = int'(rom[ROM_BASE[10:2]]);
      expOpOk[inst] = (rom[ROM_BASE[10:2]] >= 32'd1) && (rom[ROM_BASE[10:2]] <= 32'd3);
      expN[inst] = 0;
      expDoneFlag[inst] = 1'b0;
      if (!expOpOk[inst]) begin
         expT[inst] = 2;
         return;
      end
      key  = rom[ROM_BASE[10:2] + 1][7:0];
      stop = rom[ROM_BASE[10:2] + 2][7:0];
      for (int j = 0; j < maxc; j++) begin
         p = plainOf(op, rom[ROM_BASE[10:2] + 3 + j][7:0], key);
         expByte[inst][j] = p;
         expN[inst] = j + 1;
         if (p == stop) begin
            expDoneFlag[inst] = 1'b1;
            break;
         end
      end
      expT[inst] = 4 + 2 * expN[inst];
   endtask

   // Cycle-level expectations derived from the run timeline of the model.
   task automatic checkOutput(input int inst, input int k, input logic [10:0] ra,
                              input logic we, input logic [10:0] wa, input logic [31:0] wd,
                              input logic b, input logic d, input logic e, input logic [7:0] cc);
      int T, N, j, completed;
      logic [10:0] addr;
      T = expT[inst];
      N = expN[inst];
      cmp("busy", inst, k, 32'(b), 32'(k < T));
      cmp("done", inst, k, 32'(d), 32'((k >= T) && expDoneFlag[inst]));
      cmp("error", inst, k, 32'(e), 32'((k >= T) && !expDoneFlag[inst]));
      completed = (k >= 6) ? ((k - 6) / 2 + 1) : 0;
      if (completed > N) completed = N;
      cmp("char_count", inst, k, 32'(cc), 32'(completed));
      if (k >= 5 && ((k - 5) % 2 == 0) && ((k - 5) / 2 < N)) begin
         j = (k - 5) / 2;
         addr = RAM_BASE + 11'(4 * j);
         cmp("ram_we", inst, k, 32'(we), 32'd1);
         cmp("ram_address", inst, k, 32'(wa), 32'(addr));
         cmp("ram_wdata", inst, k, wd, {24'd0, expByte[inst][j]});
      end else begin
         cmp("ram_we", inst, k, 32'(we), 32'd0);
      end
      if (k == 1) cmp("rom_address", inst, k, 32'(ra), 32'(ROM_BASE));
      if (expOpOk[inst] && k == 2) cmp("rom_address", inst, k, 32'(ra), 32'(11'(ROM_BASE + 11'd4)));
      if (expOpOk[inst] && k == 3) cmp("rom_address", inst, k, 32'(ra), 32'(11'(ROM_BASE + 11'd8)));
      if (expOpOk[inst] && k >= 4 && (k % 2 == 0) && ((k - 4) / 2 < N)) begin
         addr = ROM_BASE + 11'(12 + 4 * ((k - 4) / 2));
         cmp("rom_address", inst, k, 32'(ra), 32'(addr));
      end
   endtask

   task automatic resetChecks(input string tag);
      cmp({tag, "_rom_address0"}, 0, 0, 32'(ra0), 32'(ROM_BASE));
      cmp({tag, "_ram_we0"}, 0, 0, 32'(we0), 32'd0);
      cmp({tag, "_ram_address0"}, 0, 0, 32'(wa0), 32'd0);
      cmp({tag, "_ram_wdata0"}, 0, 0, wd0, 32'd0);
      cmp({tag, "_flags0"}, 0, 0, 32'({b0, d0, e0}), 32'd0);
      cmp({tag, "_char_count0"}, 0, 0, 32'(cc0), 32'd0);
      cmp({tag, "_ram_we1"}, 1, 0, 32'(we1), 32'd0);
      cmp({tag, "_flags1"}, 1, 0, 32'({b1, d1, e1}), 32'd0);
      cmp({tag, "_char_count1"}, 1, 0, 32'(cc1), 32'd0);
   endtask

   // Compare process: count edges of the current run and check both instances.
   always @(posedge clk) begin
      if (runActive) runEdge++;
      #1;
      if (runActive && runEdge >= 1 && runEdge <= checkLimit) begin
         checkOutput(0, runEdge, ra0, we0, wa0, wd0, b0, d0, e0, cc0);
         checkOutput(1, runEdge, ra1, we1, wa1, wd1, b1, d1, e1, cc1);
         if (d0 && doneRise0 < 0) doneRise0 = runEdge;
         if (b0) begin
            if (busyFirst0 < 0) busyFirst0 = runEdge;
            busyLast0 = runEdge;
         end
      end
   end

   // RAM write monitor: records what instance 0 commits and counts writes.
   always @(posedge clk) begin
      if (we0) begin
         ram0[wa0[10:2]] = wd0;
         wc0++;
      end
      if (we1) wc1++;
   end

   task automatic applyStimulus(input bit pulseBusy);
      modelRun(0);
      modelRun(1);
      checkLimit = ((expT[0] > expT[1]) ? expT[0] : expT[1]) + 3;
      @(posedge clk);
      #2;
      start = 1'b1;
      runEdge = 0;
      doneRise0 = -1;
      busyFirst0 = -1;
      busyLast0 = -1;
      runActive = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      if (pulseBusy) begin
         @(posedge clk);
         #2 start = 1'b1;
         @(posedge clk);
         #2 start = 1'b0;
         repeat (checkLimit - 3) @(posedge clk);
      end else begin
         repeat (checkLimit - 1) @(posedge clk);
      end
      #3;
      runActive = 1'b0;
   endtask

   task automatic loadHeader(input int op, input logic [7:0] key, input logic [7:0] stop);
      rom[0] = 32'(op);
      rom[1] = {24'd0, key};
      rom[2] = {24'd0, stop};
   endtask

   initial begin
      int wcSnap0, wcSnap1, op, len;
      logic [31:0] snap [5];
      logic [31:0] w;
      logic [7:0] key, stop, p, c;

      for (int i = 0; i < 512; i++) rom[i] = $urandom;
      #1 rst = 1'b1;
      #3;
      resetChecks("reset");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // NOT decode of "HOLA&"
      loadHeader(2, 8'd3, 8'h26);
      rom[3] = 32'hFFFFFFB7; rom[4] = 32'hFFFFFFB0; rom[5] = 32'hFFFFFFB3;
      rom[6] = 32'hFFFFFFBE; rom[7] = 32'hFFFFFFD9;
      wcSnap0 = wc0;
      applyStimulus(1'b0);
      cmp("not_ram100", 0, 0, ram0[64], 32'h48);
      cmp("not_ram104", 0, 0, ram0[65], 32'h4F);
      cmp("not_ram108", 0, 0, ram0[66], 32'h4C);
      cmp("not_ram10C", 0, 0, ram0[67], 32'h41);
      cmp("not_ram110", 0, 0, ram0[68], 32'h26);
      cmp("not_writes", 0, 0, 32'(wc0 - wcSnap0), 32'd5);
      cmp("not_char_count", 0, 0, 32'(cc0), 32'd5);
      cmp("not_done_edge", 0, 0, 32'(doneRise0), 32'd14);
      cmp("not_busy_first", 0, 0, 32'(busyFirst0), 32'd1);
      cmp("not_busy_last", 0, 0, 32'(busyLast0), 32'd13);

      // Restart from DONE with a start pulse while busy; RAM must match.
      for (int i = 0; i < 5; i++) snap[i] = ram0[64 + i];
      wcSnap0 = wc0;
      applyStimulus(1'b1);
      for (int i = 0; i < 5; i++) cmp("rerun_ram", 0, i, ram0[64 + i], snap[i]);
      cmp("rerun_writes", 0, 0, 32'(wc0 - wcSnap0), 32'd5);
      cmp("rerun_done_edge", 0, 0, 32'(doneRise0), 32'd14);

      // XOR decode
      loadHeader(1, 8'd3, 8'h26);
      rom[3] = 32'h0000004B; rom[4] = 32'hABCDEF25;
      wcSnap0 = wc0;
      applyStimulus(1'b0);
      cmp("xor_ram100", 0, 0, ram0[64], 32'h48);
      cmp("xor_ram104", 0, 0, ram0[65], 32'h26);
      cmp("xor_writes", 0, 0, 32'(wc0 - wcSnap0), 32'd2);
      cmp("xor_char_count", 0, 0, 32'(cc0), 32'd2);
      cmp("xor_done", 0, 0, 32'(d0), 32'd1);

      // SUM decode with 8-bit wrap
      loadHeader(3, 8'd3, 8'h26);
      rom[3] = 32'h00000001; rom[4] = 32'h00000029;
      applyStimulus(1'b0);
      cmp("sum_ram100", 0, 0, ram0[64], 32'hFE);
      cmp("sum_ram104", 0, 0, ram0[65], 32'h26);
      cmp("sum_done", 0, 0, 32'(d0), 32'd1);

      // Invalid operation code
      rom[0] = 32'd0;
      wcSnap0 = wc0;
      wcSnap1 = wc1;
      applyStimulus(1'b0);
      cmp("badop_writes", 0, 0, 32'((wc0 - wcSnap0) + (wc1 - wcSnap1)), 32'd0);
      cmp("badop_error", 0, 0, 32'(e0), 32'd1);
      cmp("badop_char_count", 0, 0, 32'(cc0), 32'd0);

      // No stop character: the MAX_CHARS=4 instance errors after four writes
      loadHeader(1, 8'd0, 8'h00);
      for (int i = 3; i < 80; i++) begin
         w = $urandom;
         w[7:0] = 8'($urandom_range(1, 255));
         rom[i] = w;
      end
      wcSnap1 = wc1;
      applyStimulus(1'b0);
      cmp("max_writes", 1, 0, 32'(wc1 - wcSnap1), 32'd4);
      cmp("max_error", 1, 0, 32'(e1), 32'd1);
      cmp("max_done", 1, 0, 32'(d1), 32'd0);
      cmp("max_char_count", 1, 0, 32'(cc1), 32'd4);

      // Reset in the middle of a run
      loadHeader(2, 8'd0, 8'h00);
      for (int i = 3; i < 80; i++) rom[i] = 32'h00000055;
      modelRun(0);
      modelRun(1);
      checkLimit = 1000;
      @(posedge clk);
      #2;
      start = 1'b1;
      runEdge = 0;
      runActive = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      runActive = 1'b0;
      wcSnap0 = wc0;
      wcSnap1 = wc1;
      rst = 1'b1;
      #1;
      resetChecks("midrun");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      cmp("midrun_writes", 0, 0, 32'((wc0 - wcSnap0) + (wc1 - wcSnap1)), 32'd0);
      cmp("midrun_idle", 0, 0, 32'({b0, d0, e0, b1, d1, e1}), 32'd0);

      // Randomized runs against the reference model
      for (int r = 0; r < 16; r++) begin
         int sel;
         sel = $urandom_range(0, 9);
         op = (sel < 8) ? (1 + sel % 3) : ((sel == 8) ? 0 : 4 + $urandom_range(0, 100));
         key = 8'($urandom);
         stop = 8'($urandom);
         len = $urandom_range(1, 70);
         loadHeader(op, key, stop);
         for (int j = 0; j < len; j++) begin
            p = stop;
            if (j < len - 1) begin
               do p = 8'($urandom); while (p == stop);
            end
            case (op)
               1:       c = p ^ key;
               2:       c = ~p;
               default: c = p + key;
            endcase
            w = $urandom;
            w[7:0] = c;
            rom[3 + j] = w;
         end
         applyStimulus((op >= 1 && op <= 3) ? 1'($urandom_range(0, 1)) : 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
